decode_hazard_ctrl: RTL and testbench

- Scheduler for the decode stage.
- Tracks destination tags of instructions in flight in the ALU and MEM stages.
- Drives `stall_decode` and the per-operand bypass selects (RF / ALU-out / MEM-out) used by the decode operand muxes.
- Sequences pipeline freezes for load-use hazards, memory-busy stalls and exception flushes.

---
 rtl/decode_hazard_ctrl_pkg.sv | 58 +++++
 rtl/decode_hazard_ctrl_if.sv | 38 +++
 rtl/decode_hazard_ctrl_hazard_src_match.sv | 35 +++
 rtl/decode_hazard_ctrl.sv | 134 +++++++++++++
 tb/tb_decode_hazard_ctrl.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/decode_hazard_ctrl_pkg.sv
// Shared types and constants for the decode-stage hazard controller:
// in-flight tag record, bypass select encoding, opcode classes, FSM states.
package decode_hazard_ctrl_pkg;

    localparam int HZ_REG_W = 5;
    localparam int HZ_OPC_W = 7;

    // One in-flight instruction as seen by the hazard logic.
    typedef struct packed {
        logic                valid;
        logic [HZ_REG_W-1:0] rd;
        logic                writes;
        logic                is_load;
    } hazard_tag_t;

    typedef enum logic [1:0] {
        BP_RF  = 2'd0,
        BP_ALU = 2'd1,
        BP_MEM = 2'd2
    } bypass_sel_e;

    // Opcode classes; R-format occupies the whole 0x00..0x0F block.
    localparam logic [HZ_OPC_W-1:0] OPC_RTYPE   = 7'h00;
    localparam logic [HZ_OPC_W-1:0] OPC_LOAD_W  = 7'h10;
    localparam logic [HZ_OPC_W-1:0] OPC_LOAD_B  = 7'h11;
    localparam logic [HZ_OPC_W-1:0] OPC_STORE_W = 7'h12;
    localparam logic [HZ_OPC_W-1:0] OPC_STORE_B = 7'h13;
    localparam logic [HZ_OPC_W-1:0] OPC_BEQ     = 7'h30;
    localparam logic [HZ_OPC_W-1:0] OPC_JUMP    = 7'h31;

    // Scheduler states kept as plain constants so the encoding stays fixed.
    typedef logic [1:0] hz_state_e;
    localparam hz_state_e ST_RUN      = 2'd0;
    localparam hz_state_e ST_LU_STALL = 2'd1;
    localparam hz_state_e ST_MEM_WAIT = 2'd2;
    localparam hz_state_e ST_FLUSH    = 2'd3;

    // Build the tag record for the instruction sitting in decode.
    // Stores, branches, jumps and unknown opcodes never write; r0 is never a target.
    function automatic hazard_tag_t decode_tag(input logic [HZ_OPC_W-1:0] opc,
                                               input logic [HZ_REG_W-1:0] rd);
        hazard_tag_t t;
        t         = '0;
        t.valid   = 1'b1;
        t.rd      = rd;
        if (opc[HZ_OPC_W-1:4] == OPC_RTYPE[HZ_OPC_W-1:4]) begin
            t.writes = 1'b1;
        end else if (opc == OPC_LOAD_W || opc == OPC_LOAD_B) begin
            t.writes  = 1'b1;
            t.is_load = 1'b1;
        end
        if (rd == '0) begin
            t.writes = 1'b0;
        end
        return t;
    endfunction

endpackage

// File: rtl/decode_hazard_ctrl_if.sv
// Decode-stage interface: instruction fields and pipeline status in,
// stall / issue / bypass / flush controls out.
interface decode_hazard_ctrl_if
    import decode_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = HZ_REG_W,
    parameter int OPC_W      = HZ_OPC_W
);
    logic                  dec_valid;
    logic [OPC_W-1:0]      dec_opcode;
    logic [REG_ADDR_W-1:0] dec_rd;
    logic [REG_ADDR_W-1:0] dec_ra;
    logic [REG_ADDR_W-1:0] dec_rb;
    logic                  dec_use_ra;
    logic                  dec_use_rb;
    logic                  mem_busy;
    logic                  exc_valid;

    logic                  stall_decode;
    logic                  issue_valid;
    logic [1:0]            bypass_sel_a;
    logic [1:0]            bypass_sel_b;
    logic                  flush;

    // Pipeline side: presents the decode instruction and stage status.
    modport master (
        output dec_valid, dec_opcode, dec_rd, dec_ra, dec_rb,
        output dec_use_ra, dec_use_rb, mem_busy, exc_valid,
        input  stall_decode, issue_valid, bypass_sel_a, bypass_sel_b, flush
    );

    // Hazard controller side.
    modport slave (
        input  dec_valid, dec_opcode, dec_rd, dec_ra, dec_rb,
        input  dec_use_ra, dec_use_rb, mem_busy, exc_valid,
        output stall_decode, issue_valid, bypass_sel_a, bypass_sel_b, flush
    );
endinterface

// File: rtl/decode_hazard_ctrl_hazard_src_match.sv
// Compares one decode source register against the ALU and MEM stage tags.
// Produces the operand bypass select and a load-use flag for that source.
module hazard_src_match
    import decode_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = HZ_REG_W
) (
    input  logic                  use_i,
    input  logic [REG_ADDR_W-1:0] src_i,
    input  hazard_tag_t           ex_tag_i,
    input  hazard_tag_t           mem_tag_i,
    output bypass_sel_e           sel_o,
    output logic                  load_use_o
);

    logic ex_hit;
    logic mem_hit;

    assign ex_hit  = use_i && ex_tag_i.valid  && ex_tag_i.writes  && (ex_tag_i.rd  == src_i);
    assign mem_hit = use_i && mem_tag_i.valid && mem_tag_i.writes && (mem_tag_i.rd == src_i);

    // Younger ALU result wins; a load in ALU has no data yet, so fall back to MEM.
    always_comb begin
        if (ex_hit && !ex_tag_i.is_load) begin
            sel_o = BP_ALU;
        end else if (mem_hit) begin
            sel_o = BP_MEM;
        end else begin
            sel_o = BP_RF;
        end
    end

    assign load_use_o = ex_hit && ex_tag_i.is_load;

endmodule

// File: rtl/decode_hazard_ctrl.sv
// Decode-stage scheduler: tracks ALU/MEM destination tags, drives the
// operand bypass selects and sequences load-use, memory-busy and flush freezes.
module decode_hazard_ctrl
    import decode_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W   = HZ_REG_W,
    parameter int OPC_W        = HZ_OPC_W,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                 clock,
    input  logic                 reset_c,
    decode_hazard_ctrl_if.slave  bus
);

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

    hz_state_e   state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    hazard_tag_t ex_tag_q, ex_tag_d;
    hazard_tag_t mem_tag_q, mem_tag_d;

    logic [OPC_W-1:0] dec_opc;
    hazard_tag_t      dec_tag;
    bypass_sel_e      sel_a;
    bypass_sel_e      sel_b;
    logic             lu_a;
    logic             lu_b;
    logic             load_use;
    logic             stall;
    logic             issue;

    assign dec_opc = bus.dec_opcode;
    assign dec_tag = decode_tag(dec_opc, bus.dec_rd);

    hazard_src_match #(.REG_ADDR_W(REG_ADDR_W)) u_match_a (
        .use_i      (bus.dec_use_ra),
        .src_i      (bus.dec_ra),
        .ex_tag_i   (ex_tag_q),
        .mem_tag_i  (mem_tag_q),
        .sel_o      (sel_a),
        .load_use_o (lu_a)
    );

    hazard_src_match #(.REG_ADDR_W(REG_ADDR_W)) u_match_b (
        .use_i      (bus.dec_use_rb),
        .src_i      (bus.dec_rb),
        .ex_tag_i   (ex_tag_q),
        .mem_tag_i  (mem_tag_q),
        .sel_o      (sel_b),
        .load_use_o (lu_b)
    );

    assign load_use = bus.dec_valid && (lu_a || lu_b);

    // The exception cycle itself also holds decode, so the flush window is
    // that cycle plus FLUSH_CYCLES cycles spent in ST_FLUSH.
    assign stall = bus.exc_valid || (state_q != ST_RUN) || bus.mem_busy || load_use;
    assign issue = bus.dec_valid && !stall && (state_q == ST_RUN) && !bus.exc_valid;

    assign bus.stall_decode = stall;
    assign bus.issue_valid  = issue;
    assign bus.bypass_sel_a = sel_a;
    assign bus.bypass_sel_b = sel_b;
    assign bus.flush        = bus.exc_valid;

    // Next-state: exception beats everything, then per-state sequencing.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_d   = state_q;
        cnt_d     = cnt_q;
        ex_tag_d  = ex_tag_q;
        mem_tag_d = mem_tag_q;

        if (bus.exc_valid) begin
            state_d   = ST_FLUSH;
            cnt_d     = FLUSH_LOAD;
            ex_tag_d  = '0;
            mem_tag_d = '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (bus.mem_busy) begin
                        state_d = ST_MEM_WAIT;
                    end else begin
                        // A load-use stall advances too: the load moves to MEM, a bubble enters ALU.
                        if (load_use) begin
                            state_d = ST_LU_STALL;
                        end
                        mem_tag_d = ex_tag_q;
                        ex_tag_d  = issue ? dec_tag : '0;
                    end
                end
                ST_LU_STALL: begin
                    state_d = ST_RUN;
                end
                ST_MEM_WAIT: begin
                    if (!bus.mem_busy) begin
                        state_d   = ST_RUN;
                        mem_tag_d = ex_tag_q;
                        ex_tag_d  = '0;
                    end
                end
                ST_FLUSH: begin
                    if (cnt_q <= 4'd1) begin
                        state_d = ST_RUN;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // State, counter and tag registers with asynchronous clear.
    always_ff @(posedge clock or negedge reset_c) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
        if (!reset_c) begin
            state_q   <= ST_RUN;
            cnt_q     <= 4'd0;
            ex_tag_q  <= '0;
            mem_tag_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ex_tag_q  <= ex_tag_d;
            mem_tag_q <= mem_tag_d;
        end
    end

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Self-checking bench for decode_hazard_ctrl: directed vectors with literal
// expectations, plus a per-cycle comparison against a behavioural model.
module tb_decode_hazard_ctrl;

    localparam int FLUSH_CYCLES = 2;

    logic clock;
    logic reset_c;
    int   total;
    int   bad;

    decode_hazard_ctrl_if bus ();

    decode_hazard_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES)) dut (
        .clock   (clock),
        .reset_c (reset_c),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- behavioural model ----------------
    typedef struct packed {
        bit       v;
        bit [4:0] rd;
        bit       wr;
        bit       ld;
    } slot_t;

    slot_t m_ex;
    slot_t m_mem;
    int    m_flush_left;
    bit    m_in_lu;
    bit    m_in_mw;

    function automatic bit m_writes(input int opc, input int rd);
        return (rd != 0) && (opc <= 'h11);
    endfunction

    function automatic int m_sel(input bit u, input bit [4:0] src, input slot_t e, input slot_t m);
        if (u && e.v && e.wr && e.rd == src && !e.ld) return 1;
        if (u && m.v && m.wr && m.rd == src) return 2;
        return 0;
    endfunction

    function automatic bit m_lu(input bit u, input bit [4:0] src, input slot_t e);
        return u && e.v && e.wr && e.rd == src && e.ld;
    endfunction

    function automatic bit m_stall();
        bit haz;
        haz = bus.dec_valid && (m_lu(bus.dec_use_ra, bus.dec_ra, m_ex) ||
                                m_lu(bus.dec_use_rb, bus.dec_rb, m_ex));
        return bus.exc_valid || (m_flush_left > 0) || m_in_lu || m_in_mw || bus.mem_busy || haz;
    endfunction

    function automatic bit m_hazard();
        return bus.dec_valid && (m_lu(bus.dec_use_ra, bus.dec_ra, m_ex) ||
                                 m_lu(bus.dec_use_rb, bus.dec_rb, m_ex));
    endfunction

    always @(posedge clock or negedge reset_c) begin
        if (!reset_c) begin
            m_ex         <= '0;
            m_mem        <= '0;
            m_flush_left <= 0;
            m_in_lu      <= 1'b0;
            m_in_mw      <= 1'b0;
        end else if (bus.exc_valid) begin
            m_ex         <= '0;
            m_mem        <= '0;
            m_flush_left <= FLUSH_CYCLES;
            m_in_lu      <= 1'b0;
            m_in_mw      <= 1'b0;
        end else if (m_flush_left > 0) begin
            m_flush_left <= m_flush_left - 1;
        end else if (m_in_lu) begin
            m_in_lu <= 1'b0;
        end else if (m_in_mw) begin
            if (!bus.mem_busy) begin
                m_in_mw <= 1'b0;
                m_mem   <= m_ex;
                m_ex    <= '0;
            end
        end else if (bus.mem_busy) begin
            m_in_mw <= 1'b1;
        end else begin
            if (m_hazard()) m_in_lu <= 1'b1;
            m_mem <= m_ex;
            if (bus.dec_valid && !m_stall())
                m_ex <= '{v: 1'b1, rd: bus.dec_rd,
                          wr: m_writes(int'(bus.dec_opcode), int'(bus.dec_rd)),
                          ld: (bus.dec_opcode == 7'h10 || bus.dec_opcode == 7'h11)};
            else
                m_ex <= '0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clock) begin
        check("model stall", 32'(bus.stall_decode), 32'(m_stall()));
        check("model issue", 32'(bus.issue_valid), 32'(bus.dec_valid && !m_stall()));
        check("model sel_a", 32'(bus.bypass_sel_a), 32'(m_sel(bus.dec_use_ra, bus.dec_ra, m_ex, m_mem)));
        check("model sel_b", 32'(bus.bypass_sel_b), 32'(m_sel(bus.dec_use_rb, bus.dec_rb, m_ex, m_mem)));
        check("model flush", 32'(bus.flush), 32'(bus.exc_valid));
    end

    // ---------------- directed stimulus ----------------
    task automatic drive(input bit v, input int opc, input int rd, input int ra, input int rb,
                         input bit ua, input bit ub, input bit busy, input bit exc);
        bus.dec_valid  = v;
        bus.dec_opcode = 7'(opc);
        bus.dec_rd     = 5'(rd);
        bus.dec_ra     = 5'(ra);
        bus.dec_rb     = 5'(rb);
        bus.dec_use_ra = ua;
        bus.dec_use_rb = ub;
        bus.mem_busy   = busy;
        bus.exc_valid  = exc;
    endtask

    task automatic expect_out(input string tag, input int st, input int is, input int sa,
                              input int sb, input int fl);
        check({tag, " stall"}, 32'(bus.stall_decode), 32'(st));
        check({tag, " issue"}, 32'(bus.issue_valid),  32'(is));
        check({tag, " sel_a"}, 32'(bus.bypass_sel_a), 32'(sa));
        check({tag, " sel_b"}, 32'(bus.bypass_sel_b), 32'(sb));
        check({tag, " flush"}, 32'(bus.flush),        32'(fl));
    endtask

    // Apply one instruction just after the edge, then check it mid-cycle.
    task automatic step(input string tag,
                        input bit v, input int opc, input int rd, input int ra, input int rb,
                        input bit ua, input bit ub, input bit busy, input bit exc,
                        input int st, input int is, input int sa, input int sb, input int fl);
        @(posedge clock);
        #1;
        drive(v, opc, rd, ra, rb, ua, ub, busy, exc);
        @(negedge clock);
        expect_out(tag, st, is, sa, sb, fl);
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset_c = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        expect_out("reset", 0, 0, 0, 0, 0);
        @(posedge clock);
        #1 reset_c = 1'b1;

        // ALU forward, then MEM forward of the same result.
        step("add_r3",    1, 'h01, 3, 1, 2, 1, 1, 0, 0,   0, 1, 0, 0, 0);
        step("sub_fwd_a", 1, 'h02, 4, 3, 1, 1, 1, 0, 0,   0, 1, 1, 0, 0);
        step("mem_fwd_b", 1, 'h03, 6, 7, 3, 1, 1, 0, 0,   0, 1, 0, 2, 0);

        // Load-use: hazard cycle, LU_STALL cycle, then issue with MEM forward.
        step("load_r5",   1, 'h10, 5, 1, 0, 1, 0, 0, 0,   0, 1, 0, 0, 0);
        step("lu_detect", 1, 'h01, 7, 2, 5, 1, 1, 0, 0,   1, 0, 0, 0, 0);
        step("lu_stall",  1, 'h01, 7, 2, 5, 1, 1, 0, 0,   1, 0, 0, 2, 0);
        step("lu_issue",  1, 'h01, 7, 2, 5, 1, 1, 0, 0,   0, 1, 0, 2, 0);

        // r0 is never forwarded.
        step("wr_r0",     1, 'h01, 0, 1, 1, 1, 1, 0, 0,   0, 1, 0, 0, 0);
        step("rd_r0",     1, 'h01, 10, 0, 0, 1, 1, 0, 0,  0, 1, 0, 0, 0);

        // mem_busy for 3 cycles with both tags live; tags hold, then resume.
        step("add_r8",    1, 'h01, 8, 1, 1, 1, 1, 0, 0,   0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            step("mem_busy", 1, 'h01, 11, 8, 10, 1, 1, 1, 0,  1, 0, 1, 2, 0);
        step("busy_rel",  1, 'h01, 11, 8, 10, 1, 1, 0, 0, 1, 0, 1, 2, 0);
        step("busy_res",  1, 'h01, 11, 8, 10, 1, 1, 0, 0, 0, 1, 2, 0, 0);

        // Exception pulse: one flush cycle, three stalled cycles, tags gone.
        step("exc",       1, 'h01, 12, 11, 0, 1, 0, 0, 1, 1, 0, 1, 0, 1);
        step("flush_1",   1, 'h01, 12, 11, 8, 1, 1, 0, 0, 1, 0, 0, 0, 0);
        step("flush_2",   1, 'h01, 12, 11, 8, 1, 1, 0, 0, 1, 0, 0, 0, 0);
        step("post_exc",  1, 'h01, 12, 11, 8, 1, 1, 0, 0, 0, 1, 0, 0, 0);

        // exc + mem_busy together while in LU_STALL, then reset mid-flush.
        step("load_r13",  1, 'h11, 13, 1, 1, 1, 1, 0, 0,  0, 1, 0, 0, 0);
        step("lu2_det",   1, 'h01, 14, 2, 13, 1, 1, 0, 0, 1, 0, 0, 0, 0);
        step("lu2_exc",   1, 'h01, 14, 2, 13, 1, 1, 1, 1, 1, 0, 0, 2, 1);
        step("lu2_flush", 1, 'h01, 14, 2, 13, 1, 1, 0, 0, 1, 0, 0, 0, 0);
        #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset_c = 1'b0;
        #1;
        expect_out("async_rst", 0, 0, 0, 0, 0);
        @(posedge clock);
        #1 reset_c = 1'b1;
        step("after_rst", 1, 'h01, 15, 13, 14, 1, 1, 0, 0, 0, 1, 0, 0, 0);

        @(posedge clock);
        #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
